spi_receive: RTL and testbench

Dual-channel SPI master receiver for a Pmod AD1-style ADC pair (two AD7476A-class converters that share SCLK and nCS).
- On a start request it runs one 16-bit frame on both serial data lines at the same time.
- It keeps the low 12 bits of each frame.
- It pulses done when both results are valid.
- It sits between the Pmod pins and user logic that polls or triggers conversions.

---
 rtl/spi_receive_pkg.sv | 20 ++
 rtl/spi_receive_shift_in.sv | 34 +++
 rtl/spi_receive.sv | 146 ++++++++++++++
 tb/tb_spi_receive.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_receive_pkg.sv
// Shared types and constants for the dual-channel SPI ADC receiver.
package spi_receive_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int DATA_W      = 12;
  localparam int DEF_CLK_DIV = 4;
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    QUIET
  } state_e;

  // Width for a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_receive_shift_in.sv
// Serial-in shift register for one ADC channel; MSB arrives first.
module spi_shift_in
  import spi_receive_pkg::*;
#(
  parameter int W = FRAME_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         sdata,
  output logic [W-1:0] shift
);

  logic [W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clr)
      shift_d = '0;
    else if (en)
      shift_d = {shift_q[W-2:0], sdata};
  end

  always_ff @(posedge clk) begin
    if (!rst)
      shift_q <= '0;
    else
      shift_q <= shift_d;
  end

  assign shift = shift_q;

endmodule

// File: rtl/spi_receive.sv
// Dual-channel SPI master receiver: one shared SCLK/nCS frame, two data lines,
// low DATA_W bits of each 16-bit frame published with a one-cycle done pulse.
module spi_receive
  import spi_receive_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdata1,
  input  logic              sdata2,
  output logic              sclk,
  output logic              ncs,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic              start,
  output logic              done
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = cnt_w(CLK_DIV);

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   ncs_q, ncs_d;
  logic                   done_q, done_d;
  logic [DATA_W-1:0]      data1_q, data1_d;
  logic [DATA_W-1:0]      data2_q, data2_d;
  logic                   sh_clr, sh_en;
  logic [FRAME_BITS-1:0]  sh1, sh2;
  logic                   unused_hi;

  spi_shift_in #(.W(FRAME_BITS)) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .en    (sh_en),
    .sdata (sdata1),
    .shift (sh1)
  );

  spi_shift_in #(.W(FRAME_BITS)) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .en    (sh_en),
    .sdata (sdata2),
    .shift (sh2)
  );

  // The leading ADC zero bits are dropped without inspection.
  assign unused_hi = ^{sh1[FRAME_BITS-1:DATA_W], sh2[FRAME_BITS-1:DATA_W]};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    done_d  = 1'b0;
    data1_d = data1_q;
    data2_d = data2_q;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b1;
        if (start) begin
          state_d = SHIFT;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_W'(HALF - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: sample both lines while the ADC data is stable.
            sclk_d = 1'b1;
            sh_en  = 1'b1;
            bit_d  = bit_q + 1'b1;
          end else if (bit_q == BIT_CNT_W'(FRAME_BITS)) begin
            // Last high phase done: keep SCLK high, release nCS, publish.
            ncs_d   = 1'b1;
            done_d  = 1'b1;
            data1_d = sh1[DATA_W-1:0];
            data2_d = sh2[DATA_W-1:0];
            state_d = QUIET;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      QUIET: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ncs_d   = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  assign sclk  = sclk_q;
  assign ncs   = ncs_q;
  assign done  = done_q;
  assign data1 = data1_q;
  assign data2 = data2_q;

endmodule

// File: tb/tb_spi_receive.sv
// Directed bench for spi_receive with a two-channel ADC model driving MSB-first
// data on each SCLK falling edge.
module tb_spi_receive;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sdata1 = 1'b0;
  logic        sdata2 = 1'b0;
  logic        start = 1'b0;
  logic        sclk, ncs, done;
  logic [11:0] data1, data2;

  spi_receive dut (
    .clk    (clk),
    .rst    (rst),
    .sdata1 (sdata1),
    .sdata2 (sdata2),
    .sclk   (sclk),
    .ncs    (ncs),
    .data1  (data1),
    .data2  (data2),
    .start  (start),
    .done   (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC words queued per frame, consumed on each nCS falling edge.
  logic [15:0] w1 [0:63];
  logic [15:0] w2 [0:63];
  int          fptr = 0;
  logic [15:0] cur1, cur2;
  int          bp = 15;

  logic prev_sclk = 1'b1, prev_ncs = 1'b1;
  int   rise_cnt = 0, ncs_fall = 0, ncs_rise = 0, hi_run = 0, min_hi = 1000;
  int   done_n = 0;
  int   done_cyc [0:31];
  logic [11:0] dd1 [0:31];
  logic [11:0] dd2 [0:31];

  always @(negedge clk) begin
    if (ncs === 1'b0 && prev_ncs === 1'b1) begin
      ncs_fall++;
      if (hi_run < min_hi) min_hi = hi_run;
      cur1 = w1[fptr];
      cur2 = w2[fptr];
      fptr++;
      bp = 15;
      sdata1 = cur1[bp];
      sdata2 = cur2[bp];
    end else if (ncs === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
      if (bp > 0) bp--;
      sdata1 = cur1[bp];
      sdata2 = cur2[bp];
    end
    if (ncs === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) rise_cnt++;
    if (ncs === 1'b1 && prev_ncs === 1'b0) ncs_rise++;
    hi_run = (ncs === 1'b1) ? hi_run + 1 : 0;
    if (done === 1'b1 && done_n < 32) begin
      done_cyc[done_n] = cyc;
      dd1[done_n] = data1;
      dd2[done_n] = data2;
      done_n++;
    end
    prev_sclk = sclk;
    prev_ncs  = ncs;
  end

  // Launch one frame with a one-cycle start pulse and wait for done.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, output int t0);
    int base, n;
    w1[fptr] = a;
    w2[fptr] = b;
    base = done_n;
    rise_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (done_n == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_n == base) begin
      errors++;
      $display("FAIL frame_timeout: done count %0d, required %0d", done_n, base + 1);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs: got %b, want 1", ncs); end
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b, want 1", sclk); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
    checks++; if (data1 !== 12'h000) begin errors++; $display("FAIL reset_data1: got %h, want 000", data1); end
    checks++; if (data2 !== 12'h000) begin errors++; $display("FAIL reset_data2: got %h, want 000", data2); end
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ncs !== 1'b1 || sclk !== 1'b1 || done !== 1'b0 || data1 !== 12'h000 || data2 !== 12'h000)
        bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_stable: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_single();
    int t0, base;
    base = done_n;
    run_frame(16'hF05A, 16'h0A5C, t0);
    // done is raised by edge T0+64 and so is seen in the cycle after it.
    checks++; if (done_cyc[base] != t0 + 64) begin errors++; $display("FAIL single_done_time: got %0d, want %0d", done_cyc[base], t0 + 64); end
    checks++; if (dd1[base] !== 12'h05A) begin errors++; $display("FAIL single_data1: got %h, want 05a", dd1[base]); end
    checks++; if (dd2[base] !== 12'hA5C) begin errors++; $display("FAIL single_data2: got %h, want a5c", dd2[base]); end
    checks++; if (rise_cnt != 16) begin errors++; $display("FAIL single_sclk_rises: got %0d, want 16", rise_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b, want 0", done); end
    checks++; if (ncs !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL single_quiet_pins: ncs %b sclk %b, want 1 1", ncs, sclk); end
    repeat (10) @(negedge clk);
    checks++; if (data1 !== 12'h05A || done_n != base + 1) begin errors++; $display("FAIL single_hold: data1 %h dones %0d, want 05a %0d", data1, done_n, base + 1); end
  endtask

  task automatic test_extremes();
    int t0, base;
    base = done_n;
    run_frame(16'h0FFF, 16'h0000, t0);
    checks++; if (dd1[base] !== 12'hFFF) begin errors++; $display("FAIL ext1_data1: got %h, want fff", dd1[base]); end
    checks++; if (dd2[base] !== 12'h000) begin errors++; $display("FAIL ext1_data2: got %h, want 000", dd2[base]); end
    repeat (8) @(negedge clk);
    run_frame(16'h0000, 16'hFFFF, t0);
    checks++; if (dd1[base + 1] !== 12'h000) begin errors++; $display("FAIL ext2_data1: got %h, want 000", dd1[base + 1]); end
    checks++; if (dd2[base + 1] !== 12'hFFF) begin errors++; $display("FAIL ext2_data2: got %h, want fff", dd2[base + 1]); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_busy();
    int t0, base, f0, r0, mid;
    base = done_n;
    f0 = ncs_fall;
    r0 = ncs_rise;
    w1[fptr] = 16'h1234;
    w2[fptr] = 16'h5678;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk) start = 1'b0;
    while (cyc < t0 + 19) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (cyc < t0 + 40) @(negedge clk);
    mid = int'(data1);
    checks++; if (mid != int'(dd1[base - 1])) begin errors++; $display("FAIL busy_data_midframe: got %h, want %h", data1, dd1[base - 1]); end
    while (cyc < t0 + 140) @(negedge clk);
    checks++; if (done_n != base + 1) begin errors++; $display("FAIL busy_done_count: got %0d, want %0d", done_n - base, 1); end
    checks++; if (ncs_fall - f0 != 1 || ncs_rise - r0 != 1) begin errors++; $display("FAIL busy_ncs_edges: fall %0d rise %0d, want 1 1", ncs_fall - f0, ncs_rise - r0); end
    checks++; if (dd1[base] !== 12'h234 || dd2[base] !== 12'h678) begin errors++; $display("FAIL busy_data: got %h %h, want 234 678", dd1[base], dd2[base]); end
  endtask

  task automatic test_held();
    int base, n;
    logic [15:0] e1 [0:2];
    logic [15:0] e2 [0:2];
    base = done_n;
    for (int i = 0; i < 3; i++) begin
      e1[i] = 16'($urandom);
      e2[i] = 16'($urandom);
      w1[fptr + i] = e1[i];
      w2[fptr + i] = e2[i];
    end
    min_hi = 1000;
    @(negedge clk) start = 1'b1;
    n = 0;
    while (done_n < base + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (done_n < base + 3) begin
      errors++;
      $display("FAIL held_timeout: dones %0d, want 3", done_n - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dd1[base + i] !== e1[i][11:0] || dd2[base + i] !== e2[i][11:0]) begin
          errors++;
          $display("FAIL held_data%0d: got %h %h, want %h %h", i, dd1[base + i], dd2[base + i], e1[i][11:0], e2[i][11:0]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (done_cyc[base + i] - done_cyc[base + i - 1] != 69) begin
          errors++;
          $display("FAIL held_spacing%0d: got %0d, want 69", i, done_cyc[base + i] - done_cyc[base + i - 1]);
        end
      end
      checks++; if (min_hi < 4) begin errors++; $display("FAIL held_quiet: got %0d, want >=4", min_hi); end
    end
    repeat (100) @(negedge clk);
    checks++; if (done_n != base + 3) begin errors++; $display("FAIL held_stop: dones %0d, want 3", done_n - base); end
  endtask

  task automatic test_mid_reset();
    int t0, base;
    base = done_n;
    w1[fptr] = 16'hFFFF;
    w2[fptr] = 16'hFFFF;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk) start = 1'b0;
    while (cyc < t0 + 29) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ncs !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL midrst_pins: ncs %b sclk %b, want 1 1", ncs, sclk); end
    checks++; if (data1 !== 12'h000 || data2 !== 12'h000 || done !== 1'b0) begin errors++; $display("FAIL midrst_outputs: %h %h done %b, want 000 000 0", data1, data2, done); end
    rst = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (done_n != base) begin errors++; $display("FAIL midrst_no_done: got %0d, want 0", done_n - base); end
    run_frame(16'h0BCD, 16'h0357, t0);
    checks++; if (done_cyc[base] != t0 + 64) begin errors++; $display("FAIL midrst_clean_time: got %0d, want %0d", done_cyc[base], t0 + 64); end
    checks++; if (dd1[base] !== 12'hBCD || dd2[base] !== 12'h357) begin errors++; $display("FAIL midrst_clean_data: got %h %h, want bcd 357", dd1[base], dd2[base]); end
    checks++; if (rise_cnt != 16) begin errors++; $display("FAIL midrst_clean_rises: got %0d, want 16", rise_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_busy();
    test_held();
    test_mid_reset();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
